// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: marker codes, phase states, event record.
package phase_sequencer_pkg;

  localparam logic [19:0] MARKER_OPC = 20'h02013;

  localparam logic [3:0] MK_VCTM_START  = 4'd0;
  localparam logic [3:0] MK_VCTM_END    = 4'd1;
  localparam logic [3:0] MK_DELAY_START = 4'd2;
  localparam logic [3:0] MK_DELAY_END   = 4'd3;
  localparam logic [3:0] MK_TEXE_START  = 4'd4;
  localparam logic [3:0] MK_TEXE_END    = 4'd5;
  localparam logic [3:0] MK_LEAK_START  = 4'd6;
  localparam logic [3:0] MK_LEAK_END    = 4'd7;
  localparam logic [3:0] MK_INIT_START  = 4'd8;
  localparam logic [3:0] MK_INIT_END    = 4'd9;
  localparam logic [3:0] MK_BIM_START   = 4'd10;
  localparam logic [3:0] MK_BIM_END     = 4'd11;
  localparam logic [3:0] MK_TRAIN_START = 4'd12;
  localparam logic [3:0] MK_TRAIN_END   = 4'd13;
  localparam logic [3:0] MK_SIM_EXIT    = 4'd14;

  typedef enum logic [3:0] {
    PH_IDLE  = 4'd0,
    PH_VCTM  = 4'd1,
    PH_DELAY = 4'd2,
    PH_TEXE  = 4'd3,
    PH_LEAK  = 4'd4,
    PH_INIT  = 4'd5,
    PH_BIM   = 4'd6,
    PH_TRAIN = 4'd7,
    PH_EXIT  = 4'd8
  } phase_t;

  typedef struct packed {
    logic [31:0] stamp;
    logic        is_dut;
    logic [3:0]  code;
  } ev_rec_t;

  localparam int unsigned EV_W = $bits(ev_rec_t);

  // Code 15 shares the encoding but is reserved, so it is not a marker.
  function automatic logic is_marker(input logic [31:0] inst);
    return (inst[19:0] == MARKER_OPC) && (inst[31:24] == 8'h00) && (inst[23:20] != 4'hF);
  endfunction

  // Phase entered by the START code of a pair (or matched by its END).
  function automatic phase_t pair_phase(input logic [3:0] code);
    return phase_t'({1'b0, code[3:1]} + 4'd1);
  endfunction

  function automatic ev_rec_t mk_rec(input logic [3:0] code, input logic is_dut,
                                     input logic [31:0] stamp);
    ev_rec_t r;
    r.code   = code;
    r.is_dut = is_dut;
    r.stamp  = stamp;
    return r;
  endfunction

endpackage

// File: rtl/phase_sequencer_marker_fifo.sv
// Event FIFO accepting up to NPUSH in-order writes per cycle and one pop.
module marker_fifo
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NPUSH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [$clog2(NPUSH+1)-1:0]       i_push_cnt,
  input  logic [NPUSH-1:0][WIDTH-1:0]      i_push_data,
  input  logic                             i_pop,
  output logic [WIDTH-1:0]                 o_head,
  output logic                             o_valid,
  output logic [$clog2(DEPTH):0]           o_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(NPUSH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CNTW-1:0]  r_count;

  // Storage: entries 0..push_cnt-1 land at consecutive slots from the write pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPUSH; i++) begin
        if (CW'(i) < i_push_cnt) r_mem[r_wr + AW'(i)] <= i_push_data[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(i_push_cnt);
      r_rd    <= r_rd + AW'(i_pop);
      r_count <= r_count + CNTW'(i_push_cnt) - CNTW'(i_pop);
    end
  end

  // Head reads as zero while empty so the event fields are clean after reset.
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/phase_sequencer.sv
// Collects commit-stream markers into a timestamped event FIFO and tracks the DUT phase,
// transaction delay, idle timeout and end-of-simulation request.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TSX_DELAY = 4,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [LANES-1:0]                        dut_valid,
  input  logic [LANES-1:0]                        vnt_valid,
  input  logic [LANES-1:0][31:0]                  dut_inst,
  input  logic [LANES-1:0][31:0]                  vnt_inst,
  output logic                                    ev_valid,
  input  logic                                    ev_ready,
  output logic [3:0]                              ev_code,
  output logic                                    ev_is_dut,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] ev_lane,
  output logic [31:0]                             ev_time,
  output logic [3:0]                              phase,
  output logic                                    phase_err,
  output logic [15:0]                             overflow_cnt,
  output logic                                    tsx_done,
  output logic                                    timeout,
  output logic                                    finish_req
);

  localparam int unsigned NSLOT  = 2 * LANES;
  localparam int unsigned CW     = $clog2(NSLOT + 1);
  localparam int unsigned CNTW   = $clog2(DEPTH) + 1;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned DW     = EV_W + LANE_W;
  localparam logic [31:0] TSX_LOAD = (TSX_DELAY > 1) ? 32'(TSX_DELAY - 1) : 32'd0;
  localparam logic        TSX_IMM  = (TSX_DELAY <= 1);

  logic [31:0] r_cycle;
  logic [31:0] r_idle;
  phase_t      r_phase;
  logic        r_err;
  logic [15:0] r_ovf;
  logic [31:0] r_tsx_cnt;
  logic        r_tsx_done;
  logic        r_timeout;
  logic        r_finish;

  logic [NSLOT-1:0][DW-1:0] w_slot;
  logic [NSLOT-1:0]         w_slot_v;
  logic [CW-1:0]            w_pre [NSLOT];
  logic [CW-1:0]            w_n;
  logic [NSLOT-1:0][DW-1:0] w_push_data;

  // Gather markers in slot order (DUT lanes, then variant lanes) and compact them.
  always_comb begin
    w_slot      = '0;
    w_slot_v    = '0;
    w_n         = '0;
    w_push_data = '0;
    for (int s = 0; s < NSLOT; s++) w_pre[s] = '0;
    for (int i = 0; i < LANES; i++) begin
      w_slot_v[i]         = dut_valid[i] && is_marker(dut_inst[i]);
      w_slot[i]           = {LANE_W'(i), mk_rec(dut_inst[i][23:20], 1'b1, r_cycle)};
      w_slot_v[i + LANES] = vnt_valid[i] && is_marker(vnt_inst[i]);
      w_slot[i + LANES]   = {LANE_W'(i), mk_rec(vnt_inst[i][23:20], 1'b0, r_cycle)};
    end
    for (int s = 0; s < NSLOT; s++) begin
      w_pre[s] = w_n;
      w_n      = w_n + CW'(w_slot_v[s]);
    end
    for (int j = 0; j < NSLOT; j++) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (w_slot_v[s] && (w_pre[s] == CW'(j))) w_push_data[j] = w_slot[s];
      end
    end
  end

  logic [DW-1:0]   w_head;
  logic            w_fifo_valid;
  logic [CNTW-1:0] w_count;
  logic            w_pop;
  logic [CNTW-1:0] w_free;
  logic [CNTW-1:0] w_acc;
  logic [CW-1:0]   w_drop;
  logic [16:0]     w_ovf_sum;

  // Free space counts this cycle's pop; markers beyond it are dropped.
  assign w_pop     = w_fifo_valid && ev_ready;
  assign w_free    = CNTW'(DEPTH) - w_count + CNTW'(w_pop);
  assign w_acc     = (CNTW'(w_n) < w_free) ? CNTW'(w_n) : w_free;
  assign w_drop    = w_n - CW'(w_acc);
  assign w_ovf_sum = {1'b0, r_ovf} + 17'(w_drop);

  marker_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH),
    .NPUSH (NSLOT)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push_cnt  (CW'(w_acc)),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_fifo_valid),
    .o_count     (w_count)
  );

  phase_t      w_ph;
  logic        w_err;
  logic        w_trig;
  logic        w_dut_any;
  logic [3:0]  w_code;

  // DUT markers step the phase one after another in lane order.
  always_comb begin
    w_ph      = r_phase;
    w_err     = r_err;
    w_trig    = 1'b0;
    w_dut_any = 1'b0;
    w_code    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_slot_v[i]) begin
        w_dut_any = 1'b1;
        w_code    = dut_inst[i][23:20];
        if (w_code == MK_VCTM_END || w_code == MK_TEXE_START) w_trig = 1'b1;
        if (w_ph != PH_EXIT) begin
          if (w_code == MK_SIM_EXIT) begin
            w_ph = PH_EXIT;
          end else if (!w_code[0]) begin
            if (w_ph != PH_IDLE) w_err = 1'b1;
            w_ph = pair_phase(w_code);
          end else if (w_ph == pair_phase(w_code)) begin
            w_ph = PH_IDLE;
          end else begin
            w_err = 1'b1;
          end
        end
      end
    end
  end

  logic [31:0] w_idle_nxt;
  logic        w_to_nxt;

  assign w_idle_nxt = w_dut_any ? 32'd0 :
                      ((r_idle == 32'hFFFF_FFFF) ? r_idle : r_idle + 32'd1);
  assign w_to_nxt   = r_timeout || ((w_idle_nxt >= 32'(TIMEOUT)) && (w_ph != PH_EXIT));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cycle    <= '0;
      r_idle     <= '0;
      r_phase    <= PH_IDLE;
      r_err      <= 1'b0;
      r_ovf      <= '0;
      r_tsx_cnt  <= '0;
      r_tsx_done <= 1'b0;
      r_timeout  <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_idle  <= w_idle_nxt;
      r_phase <= w_ph;
      r_err   <= w_err;
      r_ovf   <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
      // Loaded one short so tsx_done is visible exactly TSX_DELAY cycles after the trigger.
      if (w_trig) begin
        r_tsx_cnt  <= TSX_LOAD;
        r_tsx_done <= TSX_IMM;
      end else if (r_tsx_cnt != 32'd0) begin
        r_tsx_cnt <= r_tsx_cnt - 32'd1;
        if (r_tsx_cnt == 32'd1) r_tsx_done <= 1'b1;
      end
      r_timeout <= w_to_nxt;
      r_finish  <= r_finish || w_to_nxt || ((r_phase == PH_EXIT) && !w_fifo_valid);
    end
  end

  assign ev_valid     = w_fifo_valid;
  assign ev_lane      = w_head[EV_W +: LANE_W];
  assign ev_code      = w_head[3:0];
  assign ev_is_dut    = w_head[4];
  assign ev_time      = w_head[EV_W-1:5];
  assign phase        = r_phase;
  assign phase_err    = r_err;
  assign overflow_cnt = r_ovf;
  assign tsx_done     = r_tsx_done;
  assign timeout      = r_timeout;
  assign finish_req   = r_finish;

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 2: commit lanes per core.
REQ-002 SHALL have parameter DEPTH, default 16: event FIFO entries, power of two, at least 2*LANES.
REQ-003 SHALL have parameter TSX_DELAY, default 4: cycles from transaction trigger to tsx_done.
REQ-004 SHALL have parameter TIMEOUT, default 1000000: idle cycles allowed without a DUT marker.
REQ-005 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have ports dut_valid / vnt_valid, input, LANES bits: per-lane commit valid for DUT / variant core.
REQ-008 SHALL have ports dut_inst / vnt_inst, input, LANES x 32 bits: per-lane committed instruction.
REQ-009 SHALL have port ev_valid, output, 1 bit: head event available.
REQ-010 SHALL have port ev_ready, input, 1 bit: consumer accepts head.
REQ-011 SHALL have ports ev_code (4), ev_is_dut (1), ev_lane (clog2(LANES), min 1), ev_time (32), all outputs: head event fields.
REQ-012 SHALL have output ports phase (4 bits), phase_err (1), overflow_cnt (16), tsx_done (1), timeout (1) and finish_req (1).

Function
REQ-013 SHALL treat an instruction as a marker iff inst[19:0]==20'h02013 and inst[31:24]==0; code=inst[23:20]; codes 0..14 valid (even=START, odd=END, 14=SIM_EXIT); code 15 and non-markers ignored.
REQ-014 SHALL define START/END pairs as 0/1 VCTM, 2/3 DELAY, 4/5 TEXE, 6/7 LEAK, 8/9 INIT, 10/11 BIM, 12/13 TRAIN.
REQ-015 SHALL push all valid markers of one cycle into the FIFO in order: DUT lane 0..LANES-1, then VNT lane 0..LANES-1, up to 2*LANES pushes per cycle.
REQ-016 SHALL, when free space < markers this cycle, push the first markers in order up to the free space, drop the rest, and add the drop count to overflow_cnt, saturating at 16'hFFFF.
REQ-017 SHALL count free space after this cycle's pop, so a full FIFO with ev_valid&&ev_ready accepts one push.
REQ-018 SHALL stamp ev_time with a free-running 32-bit cycle counter: 0 on the first cycle after reset release, wrapping modulo 2^32.
REQ-019 SHALL assert ev_valid the cycle after the first push into an empty FIFO, with no bypass, and pop on ev_valid&&ev_ready.
REQ-020 SHALL hold all ev_* fields stable while ev_valid&&!ev_ready.
REQ-021 SHALL drive phase only from DUT markers, using states IDLE=0, VCTM, DELAY, TEXE, LEAK, INIT, BIM, TRAIN, EXIT=8.
REQ-022 SHALL handle X_START as follows: go to X; if phase was not IDLE, set phase_err (sticky).
REQ-023 SHALL handle X_END as follows: if phase==X go to IDLE; otherwise set phase_err and leave phase unchanged.
REQ-024 SHALL have SIM_EXIT go to EXIT; EXIT is terminal until reset and ignores further markers.
REQ-025 SHALL, for several DUT markers in one cycle, apply them sequentially in lane order within that cycle.
REQ-026 SHALL treat DUT VCTM_END or DUT TEXE_START as a tsx trigger: clear tsx_done, load tsx counter with TSX_DELAY, decrement each cycle, and set tsx_done (sticky) when the count reaches 0, exactly TSX_DELAY cycles after the trigger cycle.
REQ-027 SHALL have a retrigger while counting restart the count.
REQ-028 SHALL reset an idle counter on every DUT marker, and set timeout (sticky) when the counter reaches TIMEOUT while phase!=EXIT.
REQ-029 SHALL assert finish_req (sticky) when (phase==EXIT and FIFO empty) or timeout.
REQ-030 SHALL ignore all inputs while reset is low.

Reset
REQ-031 SHALL, while reset==0 at a rising edge, clear the FIFO (ev_valid=0) and set ev_code/ev_is_dut/ev_lane/ev_time=0, phase=IDLE, phase_err=0, overflow_cnt=0, tsx counter=0, tsx_done=0, timeout=0, finish_req=0, and both the cycle and idle counters to 0.
REQ-032 SHALL, on reset asserted mid-operation, discard FIFO contents without popping them.

Structure
REQ-033 SHALL place marker code constants, the phase enum and the event-record typedef in shared package phase_sequencer_pkg.
REQ-034 SHALL implement the multi-push FIFO as one sub-module, marker_fifo (parameters WIDTH, DEPTH, NPUSH).

Verification
REQ-035 SHALL cover: DUT lane0 0x00802013, next cycle 0x00902013 with ev_ready=1 -> events INIT_START, INIT_END with times t, t+1; phase 5 then 0; phase_err=0.
REQ-036 SHALL cover: same cycle DUT lane0=0x00002013, lane1=0x00102013, VNT lane1=0x00602013 -> FIFO order VCTM_START/dut/0, VCTM_END/dut/1, LEAK_START/vnt/1; phase 0; tsx_done=1 exactly 4 cycles later.
REQ-037 SHALL cover: ev_ready=0, 4 markers/cycle for 5 cycles, DEPTH=16 -> 16 entries held, overflow_cnt=4, head stable throughout.
REQ-038 SHALL cover: DUT 0x00402013 then 0x00302013 -> phase_err=1, phase stays TEXE(3).
REQ-039 SHALL cover: DUT 0x00e02013 with 3 entries queued, ev_ready=1 -> finish_req rises the cycle after the FIFO empties; later markers ignored.
REQ-040 SHALL cover: TIMEOUT=100, no markers -> timeout=1 and finish_req=1 at cycle 100; then reset low for one cycle mid-stream -> all outputs return to zero values.
